// File: rtl/if_id_fetch_queue_if.sv
// IF2 -> ID fetch-queue bundle: push side from IF2, pop side to ID, plus flush.
// The master modport is the pipeline around the queue, and the slave modport is the queue itself.
interface if_id_fetch_queue_if;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic        in_adef;
  logic        in_branch_bp;
  logic        in_ready;
  logic        almost_full;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adef;
  logic        out_branch_bp;
  logic        out_after_flush;
  logic        out_ready;

  modport master (
    output flush, in_valid, in_pc, in_inst, in_adef, in_branch_bp, out_ready,
    input  in_ready, almost_full, out_valid, out_pc, out_inst, out_adef,
           out_branch_bp, out_after_flush
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, in_adef, in_branch_bp, out_ready,
    output in_ready, almost_full, out_valid, out_pc, out_inst, out_adef,
           out_branch_bp, out_after_flush
  );
endinterface

// File: rtl/if_id_fetch_queue.sv
// Decoupling FIFO between IF2 and ID. It is cleared wholesale on flush.
// The first entry pushed after a flush or reset is tagged so that ID can resynchronise.
module if_id_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_id_fetch_queue_if.slave   bus
);

  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] C_ALMOST = (PTR_W+1)'(DEPTH-1);

  logic [31:0]      r_pc   [DEPTH];
  logic [31:0]      r_inst [DEPTH];
  logic             r_adef [DEPTH];
  logic             r_bp   [DEPTH];
  logic             r_af   [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_pend_af;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  // Full is judged only on registered count, so a pop cannot make room for a push in the same cycle.
  assign w_in_ready  = (r_count != C_DEPTH);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

  assign bus.in_ready        = w_in_ready;
  assign bus.almost_full     = (r_count >= C_ALMOST);
  assign bus.out_valid       = w_out_valid;
  assign bus.out_pc          = r_pc[r_rd_ptr];
  assign bus.out_inst        = r_inst[r_rd_ptr];
  assign bus.out_adef        = r_adef[r_rd_ptr];
  assign bus.out_branch_bp   = r_bp[r_rd_ptr];
  assign bus.out_after_flush = r_af[r_rd_ptr];

  // A flush leaves storage untouched; only the pointers and the count are cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
        r_adef[i] <= 1'b0;
        r_bp[i]   <= 1'b0;
        r_af[i]   <= 1'b0;
      end
    end else if (w_push) begin
      r_pc[r_wr_ptr]   <= bus.in_pc;
      r_inst[r_wr_ptr] <= bus.in_inst;
      r_adef[r_wr_ptr] <= bus.in_adef;
      r_bp[r_wr_ptr]   <= bus.in_branch_bp;
      r_af[r_wr_ptr]   <= r_pend_af;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_pend_af <= 1'b1;
    end else if (bus.flush) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_pend_af <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr  <= r_wr_ptr + 1'b1;
        r_pend_af <= 1'b0;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Bench for if_id_fetch_queue: directed stimulus with a scoreboard of expected pops.
// A negedge monitor compares each handshaked head entry against the scoreboard.
module tb_if_id_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
    logic        bp;
    logic        af;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  ent_t exp_q[$];

  if_id_fetch_queue_if bus ();

  if_id_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each handshake seen here is committed at the next posedge.
  always @(negedge clk) begin
    if (rst_n && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %0h expected no entry", bus.out_pc);
      end else begin
        ent_t e;
        ent_t a;
        e = exp_q.pop_front();
        a = '{pc: bus.out_pc, inst: bus.out_inst, adef: bus.out_adef,
              bp: bus.out_branch_bp, af: bus.out_after_flush};
        chk("pop_entry", 67'(a), 67'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic adef, input logic bp);
    bus.in_valid     = v;
    bus.in_pc        = pc;
    bus.in_inst      = inst;
    bus.in_adef      = adef;
    bus.in_branch_bp = bp;
  endtask

  // Presents one push for one cycle; 'acc' says whether the hand-computed outcome is acceptance.
  task automatic push1(input logic [31:0] pc, input logic [31:0] inst, input logic adef,
                       input logic bp, input logic af, input logic acc);
    set_in(1'b1, pc, inst, adef, bp);
    if (acc) exp_q.push_back('{pc: pc, inst: inst, adef: adef, bp: bp, af: af});
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    bus.out_ready = 1'b1;
    repeat (n) tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 67'(bus.out_valid), 67'(1'b0));
    chk("rst_in_ready", 67'(bus.in_ready), 67'(1'b1));
    chk("rst_almost_full", 67'(bus.almost_full), 67'(1'b0));
    chk("rst_out_pc", 67'(bus.out_pc), 67'(32'h0));

    // Three pushes with ID stalled; only the first carries the after-flush tag.
    push1(32'h1c000000, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1);
    push1(32'h1c000004, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    push1(32'h1c000008, 32'h33, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("c3_almost_full", 67'(bus.almost_full), 67'(1'b1));
    chk("c3_in_ready", 67'(bus.in_ready), 67'(1'b1));
    chk("c3_head_pc", 67'(bus.out_pc), 67'(32'h1c000000));
    chk("c3_head_af", 67'(bus.out_after_flush), 67'(1'b1));
    drain(3);
    chk("drain3_out_valid", 67'(bus.out_valid), 67'(1'b0));

    // Fill to full. A push offered together with a pop must be rejected.
    push1(32'h1c000020, 32'ha0, 1'b0, 1'b0, 1'b0, 1'b1);
    push1(32'h1c000024, 32'ha1, 1'b0, 1'b1, 1'b0, 1'b1);
    push1(32'h1c000028, 32'ha2, 1'b0, 1'b0, 1'b0, 1'b1);
    push1(32'h1c00002c, 32'ha3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("full_in_ready", 67'(bus.in_ready), 67'(1'b0));
    chk("full_almost_full", 67'(bus.almost_full), 67'(1'b1));
    bus.out_ready = 1'b1;
    push1(32'h1c0000ee, 32'hee, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    chk("after_rej_in_ready", 67'(bus.in_ready), 67'(1'b1));
    chk("after_rej_almost_full", 67'(bus.almost_full), 67'(1'b1));
    drain(3);
    chk("drain_full_out_valid", 67'(bus.out_valid), 67'(1'b0));

    // Push into an empty queue is not visible until the next cycle. Then push and pop every cycle.
    set_in(1'b1, 32'h1c000010, 32'h10, 1'b0, 1'b0);
    exp_q.push_back('{pc: 32'h1c000010, inst: 32'h10, adef: 1'b0, bp: 1'b0, af: 1'b0});
    chk("lat_cycleN_out_valid", 67'(bus.out_valid), 67'(1'b0));
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("lat_cycleN1_out_valid", 67'(bus.out_valid), 67'(1'b1));
    chk("lat_cycleN1_out_pc", 67'(bus.out_pc), 67'(32'h1c000010));
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] pc;
      pc = 32'h1c000014 + 32'(4 * k);
      set_in(1'b1, pc, 32'h100 + 32'(k), 1'b0, k[0]);
      exp_q.push_back('{pc: pc, inst: 32'h100 + 32'(k), adef: 1'b0, bp: k[0], af: 1'b0});
      tick();
      chk("steady_out_valid", 67'(bus.out_valid), 67'(1'b1));
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("steady_almost_full", 67'(bus.almost_full), 67'(1'b0));
    tick();
    bus.out_ready = 1'b0;
    chk("steady_end_out_valid", 67'(bus.out_valid), 67'(1'b0));

    // A flush arriving together with a push and a pop drops both.
    push1(32'h1c000030, 32'hb0, 1'b0, 1'b0, 1'b0, 1'b1);
    push1(32'h1c000034, 32'hb1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    set_in(1'b1, 32'h1c0000ff, 32'hff, 1'b0, 1'b0);
    tick();
    exp_q.delete();
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("flush_out_valid", 67'(bus.out_valid), 67'(1'b0));
    chk("flush_in_ready", 67'(bus.in_ready), 67'(1'b1));
    chk("flush_almost_full", 67'(bus.almost_full), 67'(1'b0));
    push1(32'h1c000100, 32'hc0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("post_flush_af", 67'(bus.out_after_flush), 67'(1'b1));
    chk("post_flush_pc", 67'(bus.out_pc), 67'(32'h1c000100));
    drain(1);

    // The adef and prediction tags pass through with the instruction word unmodified.
    push1(32'h1c000200, 32'hdeadbeef, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("adef_out_adef", 67'(bus.out_adef), 67'(1'b1));
    chk("adef_out_bp", 67'(bus.out_branch_bp), 67'(1'b1));
    chk("adef_out_inst", 67'(bus.out_inst), 67'(32'hdeadbeef));
    drain(1);

    // Reset while the queue is full.
    push1(32'h1c000300, 32'hd0, 1'b0, 1'b0, 1'b0, 1'b1);
    push1(32'h1c000304, 32'hd1, 1'b0, 1'b0, 1'b0, 1'b1);
    push1(32'h1c000308, 32'hd2, 1'b0, 1'b0, 1'b0, 1'b1);
    push1(32'h1c00030c, 32'hd3, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("prerst_in_ready", 67'(bus.in_ready), 67'(1'b0));
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    rst_n = 1'b1;
    chk("midrst_out_valid", 67'(bus.out_valid), 67'(1'b0));
    chk("midrst_in_ready", 67'(bus.in_ready), 67'(1'b1));
    chk("midrst_out_pc", 67'(bus.out_pc), 67'(32'h0));
    chk("midrst_out_inst", 67'(bus.out_inst), 67'(32'h0));
    chk("midrst_almost_full", 67'(bus.almost_full), 67'(1'b0));
    push1(32'h1c000400, 32'he0, 1'b0, 1'b0, 1'b1, 1'b1);
    drain(1);
    tick();

    chk("scoreboard_empty", 67'(exp_q.size()), 67'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
